// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared constants, state encoding and rank helper for the card shoe
package card_pkg;

    localparam int DECK_SIZE = 52;

    // x^6 + x^5 + 1: feedback is the XOR of bits 5 and 4
    localparam logic [5:0] LFSR_TAPS = 6'b110000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PICK,
        S_SWAP,
        S_DEAL,
        S_HOLD
    } state_t;

    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

endpackage

// File: rtl/lfsr6.sv
// rtl/lfsr6.sv - 6-bit shuffle LFSR with seed load and zero-seed substitution
module lfsr6 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] seed_in,
    input  logic       advance,
    output logic [5:0] q
);
    import card_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 6'b000001;
        end else if (load) begin
            // an all-zero state would lock the register, so it is never loaded
            q <= (seed_in == 6'd0) ? 6'b000001 : seed_in;
        end else if (advance) begin
            q <= {q[4:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - 52-card deck store with seeded Fisher-Yates shuffle and handshake dealing
module card_shoe #(
    parameter int DECK_SIZE = card_pkg::DECK_SIZE,
    parameter int SEED_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_start,
    output logic              shuffle_ready,
    input  logic [SEED_W-1:0] seed,
    input  logic              card_start,
    output logic              card_ready,
    output logic [3:0]        card,
    output logic              card_overflow
);
    import card_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
    localparam logic [5:0] END_PTR  = 6'(DECK_SIZE);

    state_t            state;
    logic [3:0]        deck [0:DECK_SIZE-1];
    logic [5:0]        ptr;
    logic [5:0]        i;
    logic [5:0]        j;
    logic [SEED_W-1:0] seed_q;
    logic [5:0]        lfsr_q;
    logic [5:0]        r;
    logic              accept;
    logic              lfsr_load;
    logic              lfsr_adv;

    assign r         = lfsr_q - 6'd1;
    assign accept    = (r <= i);
    assign lfsr_load = (state == S_LOAD);
    // rejected picks draw again; every swap consumes the accepted value
    assign lfsr_adv  = ((state == S_PICK) && !accept) || (state == S_SWAP);

    lfsr6 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed_in (seed_q),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            for (int k = 0; k < DECK_SIZE; k++) begin
                deck[k] <= rank_to_value(4'(k % 13 + 1));
            end
            ptr           <= 6'd0;
            i             <= 6'd0;
            j             <= 6'd0;
            seed_q        <= '0;
            shuffle_ready <= 1'b1;
            card_ready    <= 1'b0;
            card          <= 4'd0;
            card_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (shuffle_start) begin
                        seed_q <= seed;
                        state  <= S_LOAD;
                    end else if (card_start) begin
                        state <= S_DEAL;
                    end
                end
                S_LOAD: begin
                    for (int k = 0; k < DECK_SIZE; k++) begin
                        deck[k] <= rank_to_value(4'(k % 13 + 1));
                    end
                    i             <= LAST_IDX;
                    ptr           <= 6'd0;
                    card_overflow <= 1'b0;
                    shuffle_ready <= 1'b0;
                    state         <= S_PICK;
                end
                S_PICK: begin
                    if (accept) begin
                        j     <= r;
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    deck[i] <= deck[j];
                    deck[j] <= deck[i];
                    i       <= i - 6'd1;
                    if (i == 6'd1) begin
                        shuffle_ready <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        state <= S_PICK;
                    end
                end
                S_DEAL: begin
                    if (ptr == END_PTR) begin
                        card_overflow <= 1'b1;
                        card          <= deck[0];
                        ptr           <= 6'd1;
                    end else begin
                        card <= deck[ptr];
                        ptr  <= ptr + 6'd1;
                    end
                    card_ready <= 1'b1;
                    state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (!card_start) begin
                        card_ready <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - self-checking bench for card_shoe against a deck-level reference model
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       rst;
    logic       shuffle_start;
    logic       shuffle_ready;
    logic [5:0] seed;
    logic       card_start;
    logic       card_ready;
    logic [3:0] card;
    logic       card_overflow;

    always #5 clk = ~clk;

    card_shoe dut (
        .clk           (clk),
        .rst           (rst),
        .shuffle_start (shuffle_start),
        .shuffle_ready (shuffle_ready),
        .seed          (seed),
        .card_start    (card_start),
        .card_ready    (card_ready),
        .card          (card),
        .card_overflow (card_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic       chk_en = 1'b0;
    logic       exp_sready;
    logic       exp_ready;
    logic       exp_ov;
    logic [3:0] exp_card;

    int mdeck [52];
    int mptr;
    int shuf_deck [52];
    int shuf_picks;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("shuffle_ready", {7'd0, shuffle_ready}, {7'd0, exp_sready});
            check("card_ready", {7'd0, card_ready}, {7'd0, exp_ready});
            check("card", {4'd0, card}, {4'd0, exp_card});
            check("card_overflow", {7'd0, card_overflow}, {7'd0, exp_ov});
        end
    end

    function automatic int ordered_val(input int k);
        return (k % 13 + 1 > 10) ? 10 : k % 13 + 1;
    endfunction

    function automatic int lfsr_next(input int v);
        return ((v << 1) & 63) | (((v >> 5) ^ (v >> 4)) & 1);
    endfunction

    // Fisher-Yates from card 51 down to 1, drawing j = lfsr-1 and redrawing while j > i
    task automatic model_shuffle(input int s);
        int l;
        int t;
        int rr;
        for (int k = 0; k < 52; k++) shuf_deck[k] = ordered_val(k);
        l = (s == 0) ? 1 : s;
        shuf_picks = 0;
        for (int ii = 51; ii >= 1; ii--) begin
            while (l - 1 > ii) begin
                l = lfsr_next(l);
                shuf_picks++;
            end
            shuf_picks++;
            rr = l - 1;
            t = shuf_deck[ii];
            shuf_deck[ii] = shuf_deck[rr];
            shuf_deck[rr] = t;
            l = lfsr_next(l);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        shuffle_start = 1'b0;
        card_start = 1'b0;
        tick();
        rst = 1'b0;
        exp_sready = 1'b1;
        exp_ready = 1'b0;
        exp_card = 4'd0;
        exp_ov = 1'b0;
        for (int k = 0; k < 52; k++) mdeck[k] = ordered_val(k);
        mptr = 0;
    endtask

    task automatic deal_model();
        if (mptr == 52) begin
            exp_ov = 1'b1;
            exp_card = 4'(mdeck[0]);
            mptr = 1;
        end else begin
            exp_card = 4'(mdeck[mptr]);
            mptr++;
        end
        exp_ready = 1'b1;
    endtask

    task automatic deal(input int hold, output logic [3:0] got);
        card_start = 1'b1;
        tick();
        tick();
        deal_model();
        got = card;
        repeat (hold) tick();
        card_start = 1'b0;
        tick();
        exp_ready = 1'b0;
    endtask

    task automatic shuffle(input int s, input bit with_card);
        model_shuffle(s);
        seed = 6'(s);
        shuffle_start = 1'b1;
        if (with_card) card_start = 1'b1;
        tick();
        shuffle_start = 1'b0;
        seed = 6'($urandom);
        tick();
        exp_sready = 1'b0;
        exp_ov = 1'b0;
        for (int k = 0; k < 52; k++) mdeck[k] = shuf_deck[k];
        mptr = 0;
        repeat (shuf_picks + 50) tick();
        tick();
        exp_sready = 1'b1;
    endtask

    logic [3:0] got;
    logic [3:0] first;
    int hist [11];
    int ref_deck [52];

    initial begin
        rst = 1'b1;
        shuffle_start = 1'b0;
        card_start = 1'b0;
        seed = 6'd0;
        tick();
        do_reset();
        chk_en = 1'b1;

        check("reset shuffle_ready", {7'd0, shuffle_ready}, 8'd1);
        check("reset card_ready", {7'd0, card_ready}, 8'd0);
        check("reset card", {4'd0, card}, 8'd0);

        for (int k = 0; k < 4; k++) begin
            deal($urandom_range(0, 2), got);
            check("unshuffled card", {4'd0, got}, 8'(k + 1));
        end
        check("unshuffled overflow", {7'd0, card_overflow}, 8'd0);

        shuffle(6'h0A, 1'b0);
        for (int v = 0; v < 11; v++) hist[v] = 0;
        for (int k = 0; k < 52; k++) begin
            deal($urandom_range(0, 1), got);
            if (k == 0) first = got;
            if (got <= 4'd10) hist[got]++;
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int v = 1; v <= 9; v++) check("multiset count", 8'(hist[v]), 8'd4);
        check("multiset tens", 8'(hist[10]), 8'd16);
        check("no overflow after 52", {7'd0, card_overflow}, 8'd0);

        deal(0, got);
        check("wrap card", {4'd0, got}, {4'd0, first});
        check("wrap overflow", {7'd0, card_overflow}, 8'd1);
        shuffle(int'($urandom_range(1, 63)), 1'b0);
        check("overflow cleared", {7'd0, card_overflow}, 8'd0);

        model_shuffle(1);
        for (int k = 0; k < 52; k++) ref_deck[k] = shuf_deck[k];
        shuffle(0, 1'b0);
        for (int k = 0; k < 52; k++) begin
            deal(0, got);
            check("zero seed card", {4'd0, got}, 8'(ref_deck[k]));
        end

        shuffle(int'($urandom_range(0, 63)), 1'b1);
        deal(1, got);
        check("simultaneous first card", {4'd0, got}, 8'(mdeck[0]));

        model_shuffle(6'h2B);
        seed = 6'h2B;
        shuffle_start = 1'b1;
        tick();
        shuffle_start = 1'b0;
        tick();
        exp_sready = 1'b0;
        exp_ov = 1'b0;
        repeat (20) tick();
        do_reset();
        check("mid-shuffle reset ready", {7'd0, shuffle_ready}, 8'd1);
        for (int k = 0; k < 13; k++) begin
            deal(0, got);
            check("ordered after reset", {4'd0, got}, 8'(ordered_val(k)));
        end

        card_start = 1'b1;
        tick();
        tick();
        deal_model();
        tick();
        do_reset();
        check("mid-hold reset card_ready", {7'd0, card_ready}, 8'd0);

        repeat (5) begin
            shuffle(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 60)) begin
                deal($urandom_range(0, 2), got);
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
